// File: rtl/or1200_vlx_huff_enc.sv
// +--------------------------------------------------------------------------+
// | or1200_vlx_huff_enc                                                      |
// | JPEG baseline symbol encoder: DC prediction, AC run-length, Huffman LUT. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module or1200_vlx_huff_enc #(
  parameter int NCOMP   = 2,
  parameter int MAXSIZE = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               coef_valid_i,
  output logic               coef_ready_o,
  input  logic [10:0]        coef_i,
  input  logic               comp_i,
  input  logic               dc_clr_i,
  input  logic               tbl_we_i,
  input  logic [9:0]         tbl_addr_i,
  input  logic [20:0]        tbl_dat_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [MAXSIZE-1:0] out_dat_o,
  output logic [4:0]         out_size_o,
  output logic               block_done_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ZRL  = 3'd1,
    RD   = 3'd2,
    CODE = 3'd3,
    AMP  = 3'd4,
    EOB  = 3'd5
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_k, r_run;
  logic [1:0]  r_nzrl;
  logic        r_comp, r_is_dc, r_last;
  logic [10:0] r_pred [NCOMP];
  logic [20:0] r_zrl  [NCOMP];
  logic [20:0] r_eob  [NCOMP];
  logic [11:0] r_v;
  logic [3:0]  r_cat;
  logic [20:0] r_mem  [0:1023];
  logic [20:0] r_rd_dat;

  logic        w_accept;
  logic [10:0] w_coef_sat, w_pred_sel;
  logic [11:0] w_diff, w_v, w_amp;
  logic [3:0]  w_cat;
  logic [9:0]  w_addr;

  function automatic logic [3:0] cat_of(input logic [11:0] v);
    logic [11:0] a;
    a = v[11] ? (~v + 12'd1) : v;
    cat_of = 4'd0;
    for (int i = 0; i < 12; i++)
      if (a[i]) cat_of = 4'(i + 1);
  endfunction

  assign w_accept   = coef_valid_i && (r_state == IDLE);
  assign w_coef_sat = (coef_i == 11'h400) ? 11'h401 : coef_i;
  // A restart clear in the same cycle as the DC accept wins over the stored predictor
  assign w_pred_sel = dc_clr_i ? 11'd0 : r_pred[comp_i];
  assign w_diff     = {w_coef_sat[10], w_coef_sat} - {w_pred_sel[10], w_pred_sel};
  assign w_v        = (r_k == 6'd0) ? w_diff : {w_coef_sat[10], w_coef_sat};
  assign w_cat      = cat_of(w_v);
  assign w_amp      = r_v[11] ? (r_v - 12'd1) : r_v;
  assign w_addr     = {r_comp, r_is_dc, r_is_dc ? {4'd0, r_cat} : {r_run[3:0], r_cat}};

  always_ff @(posedge clk_i) begin
    if (tbl_we_i) r_mem[tbl_addr_i] <= tbl_dat_i;
    if (r_state == RD) r_rd_dat <= r_mem[w_addr];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    coef_ready_o = 1'b0;
    out_valid_o  = 1'b0;
    out_dat_o    = '0;
    out_size_o   = 5'd0;
    block_done_o = 1'b0;
    case (r_state)
      IDLE: begin
        coef_ready_o = 1'b1;
        if (coef_valid_i) begin
          if (r_k == 6'd0)          w_next = RD;
          else if (coef_i == 11'd0) w_next = (r_k == 6'd63) ? EOB : IDLE;
          else                      w_next = (r_run[5:4] != 2'd0) ? ZRL : RD;
        end
      end
      ZRL: begin
        out_valid_o = 1'b1;
        out_dat_o   = MAXSIZE'(r_zrl[r_comp][15:0]);
        out_size_o  = r_zrl[r_comp][20:16];
        if (out_ready_i && r_nzrl == 2'd1) w_next = RD;
      end
      RD: w_next = CODE;
      CODE: begin
        out_valid_o = 1'b1;
        out_dat_o   = MAXSIZE'(r_rd_dat[15:0]);
        out_size_o  = r_rd_dat[20:16];
        if (out_ready_i) w_next = (r_cat != 4'd0) ? AMP : IDLE;
      end
      AMP: begin
        out_valid_o  = 1'b1;
        out_dat_o    = MAXSIZE'(w_amp) & ((MAXSIZE'(1) << r_cat) - MAXSIZE'(1));
        out_size_o   = {1'b0, r_cat};
        block_done_o = out_ready_i && r_last;
        if (out_ready_i) w_next = IDLE;
      end
      EOB: begin
        out_valid_o  = 1'b1;
        out_dat_o    = MAXSIZE'(r_eob[r_comp][15:0]);
        out_size_o   = r_eob[r_comp][20:16];
        block_done_o = out_ready_i;
        if (out_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_k     <= 6'd0;
      r_run   <= 6'd0;
      r_nzrl  <= 2'd0;
      r_comp  <= 1'b0;
      r_is_dc <= 1'b0;
      r_last  <= 1'b0;
      r_v     <= 12'd0;
      r_cat   <= 4'd0;
      for (int i = 0; i < NCOMP; i++) begin
        r_pred[i] <= 11'd0;
        r_zrl[i]  <= 21'd0;
        r_eob[i]  <= 21'd0;
      end
    end else begin
      if (dc_clr_i)
        for (int i = 0; i < NCOMP; i++) r_pred[i] <= 11'd0;
      if (w_accept) begin
        r_k <= r_k + 6'd1;
        if (r_k == 6'd0) begin
          r_comp         <= comp_i;
          r_is_dc        <= 1'b1;
          r_last         <= 1'b0;
          r_v            <= w_v;
          r_cat          <= w_cat;
          r_pred[comp_i] <= w_coef_sat;
        end else begin
          r_is_dc <= 1'b0;
          r_last  <= (r_k == 6'd63);
          if (coef_i == 11'd0) begin
            r_run <= r_run + 6'd1;
          end else begin
            r_nzrl <= r_run[5:4];
            r_run  <= {2'd0, r_run[3:0]};
            r_v    <= w_v;
            r_cat  <= w_cat;
          end
        end
      end
      if (r_state == ZRL && out_ready_i) r_nzrl <= r_nzrl - 2'd1;
      if ((r_state == AMP || r_state == EOB) && out_ready_i) r_run <= 6'd0;
      // ZRL and EOB codes are shadowed so they can be emitted without a RAM read
      if (tbl_we_i && !tbl_addr_i[8]) begin
        if (tbl_addr_i[7:0] == 8'hF0) r_zrl[tbl_addr_i[9]] <= tbl_dat_i;
        if (tbl_addr_i[7:0] == 8'h00) r_eob[tbl_addr_i[9]] <= tbl_dat_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_or1200_vlx_huff_enc.sv
// Bench for or1200_vlx_huff_enc: standard JPEG tables, directed blocks, then random blocks
// checked against a block-level entropy-coding model.
`default_nettype none

module tb_or1200_vlx_huff_enc;

  logic        clk_i = 1'b0;
  logic        rst_i, coef_valid_i, comp_i, dc_clr_i, tbl_we_i, out_ready_i;
  logic        coef_ready_o, out_valid_o, block_done_o;
  logic [10:0] coef_i;
  logic [9:0]  tbl_addr_i;
  logic [20:0] tbl_dat_i;
  logic [15:0] out_dat_o;
  logic [4:0]  out_size_o;

  or1200_vlx_huff_enc #(.NCOMP(2), .MAXSIZE(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .coef_valid_i(coef_valid_i), .coef_ready_o(coef_ready_o),
    .coef_i(coef_i), .comp_i(comp_i), .dc_clr_i(dc_clr_i),
    .tbl_we_i(tbl_we_i), .tbl_addr_i(tbl_addr_i), .tbl_dat_i(tbl_dat_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_dat_o(out_dat_o), .out_size_o(out_size_o), .block_done_o(block_done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic [10:0] blk [64];
  logic [20:0] exp_q [$];
  int          mpred [2];
  logic [15:0] tcode [2][2][256];
  logic [4:0]  tlen  [2][2][256];

  int dcl_bits [16] = '{0,1,5,1,1,1,1,1,1,0,0,0,0,0,0,0};
  int dcc_bits [16] = '{0,3,1,1,1,1,1,1,1,1,1,0,0,0,0,0};
  int acl_bits [16] = '{0,2,1,3,3,2,4,3,5,5,4,4,0,0,1,125};
  int aclit [65] = '{
    8'h01,8'h02,8'h03,8'h00,8'h04,8'h11,8'h05,8'h12,
    8'h21,8'h31,8'h41,8'h06,8'h13,8'h51,8'h61,8'h07,
    8'h22,8'h71,8'h14,8'h32,8'h81,8'h91,8'ha1,8'h08,
    8'h23,8'h42,8'hb1,8'hc1,8'h15,8'h52,8'hd1,8'hf0,
    8'h24,8'h33,8'h62,8'h72,8'h82,8'h09,8'h0a,8'h16,
    8'h17,8'h18,8'h19,8'h1a,8'h25,8'h26,8'h27,8'h28,
    8'h29,8'h2a,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,
    8'h3a,8'h43,8'h44,8'h45,8'h46,8'h47,8'h48,8'h49,
    8'h4a};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Canonical Huffman code assignment from a BITS/HUFFVAL pair, then RAM load
  task automatic gen_tbl(input int set, input int dc, input int bits[16], input int vals[$], input bit inv);
    int code = 0;
    int p = 0;
    for (int l = 1; l <= 16; l++) begin
      for (int n = 0; n < bits[l-1]; n++) begin
        tlen[set][dc][vals[p]]  = 5'(l);
        tcode[set][dc][vals[p]] = inv ? 16'(~code & ((1 << l) - 1)) : 16'(code);
        code++;
        p++;
      end
      code = code << 1;
    end
    foreach (vals[i]) begin
      @(negedge clk_i);
      tbl_we_i   = 1'b1;
      tbl_addr_i = 10'(set * 512 + dc * 256 + vals[i]);
      tbl_dat_i  = {tlen[set][dc][vals[i]], tcode[set][dc][vals[i]]};
    end
    @(negedge clk_i);
    tbl_we_i = 1'b0;
  endtask

  task automatic load_tables();
    int dcv[$];
    int acv[$];
    for (int i = 0; i < 12; i++) dcv.push_back(i);
    for (int i = 0; i < 65; i++) acv.push_back(aclit[i]);
    for (int r = 5; r <= 8; r++)   for (int l = 3; l <= 10; l++) acv.push_back(r * 16 + l);
    for (int r = 9; r <= 13; r++)  for (int l = 2; l <= 10; l++) acv.push_back(r * 16 + l);
    for (int r = 14; r <= 15; r++) for (int l = 1; l <= 10; l++) acv.push_back(r * 16 + l);
    gen_tbl(0, 1, dcl_bits, dcv, 1'b0);
    gen_tbl(0, 0, acl_bits, acv, 1'b0);
    gen_tbl(1, 1, dcc_bits, dcv, 1'b0);
    gen_tbl(1, 0, acl_bits, acv, 1'b1);
  endtask

  task automatic push_beat(input int code, input int len);
    exp_q.push_back({5'(len), 16'(code)});
  endtask

  function automatic int catf(input int v);
    int a = (v < 0) ? -v : v;
    int c = 0;
    while (a > 0) begin a = a >> 1; c++; end
    return c;
  endfunction

  function automatic int ampf(input int v, input int c);
    return (v < 0) ? v + (1 << c) - 1 : v;
  endfunction

  // Whole-block reference: prediction, run-length/ZRL/EOB rules, table lookups
  task automatic model_block(input int comp, input bit clr);
    int c[64];
    int d, ct, run;
    for (int i = 0; i < 64; i++) begin
      c[i] = int'($signed(blk[i]));
      if (c[i] == -1024) c[i] = -1023;
    end
    if (clr) mpred = '{0, 0};
    d = c[0] - mpred[comp];
    mpred[comp] = c[0];
    ct = catf(d);
    push_beat(tcode[comp][1][ct], tlen[comp][1][ct]);
    if (ct > 0) push_beat(ampf(d, ct), ct);
    run = 0;
    for (int k = 1; k < 64; k++) begin
      if (c[k] == 0) run++;
      else begin
        while (run >= 16) begin
          push_beat(tcode[comp][0][8'hF0], tlen[comp][0][8'hF0]);
          run -= 16;
        end
        ct = catf(c[k]);
        push_beat(tcode[comp][0][run * 16 + ct], tlen[comp][0][run * 16 + ct]);
        push_beat(ampf(c[k], ct), ct);
        run = 0;
      end
    end
    if (run > 0) push_beat(tcode[comp][0][0], tlen[comp][0][0]);
  endtask

  task automatic rand_blk(input int density);
    int x;
    blk[0] = 11'($urandom);
    for (int i = 1; i < 64; i++) begin
      x = 0;
      if ($urandom_range(0, 99) < density)
        x = int'($signed(11'($urandom))) >>> $urandom_range(0, 10);
      blk[i] = 11'(x);
      if ($urandom_range(0, 60) == 0) blk[i] = 11'h400;
    end
  endtask

  function automatic void clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 11'd0;
  endfunction

  // stall: cycles ready is held low per beat; -1 = random ready and valid gaps
  task automatic run_block(input int comp, input bit clr, input int stall, input int abort_at);
    int idx = 0, cyc = 0, wcnt = 0;
    bit hold = 1'b0, acc, hs, last;
    logic [15:0] hd;
    logic [4:0]  hsz;
    logic [20:0] e;
    while (cyc < 4000) begin
      @(negedge clk_i);
      if (hold) begin
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_dat", 32'(out_dat_o), 32'(hd));
        chk("stall_size", 32'(out_size_o), 32'(hsz));
      end
      if (abort_at < 0 && idx == 64 && exp_q.size() == 0) break;
      if (abort_at >= 0 && idx >= abort_at) break;
      coef_valid_i = (idx < 64) && (stall >= 0 || $urandom_range(0, 3) != 0);
      coef_i       = (idx < 64) ? blk[idx] : 11'd0;
      comp_i       = (idx == 0) ? 1'(comp) : 1'($urandom_range(0, 1));
      dc_clr_i     = clr && (cyc == 0);
      out_ready_i  = (stall < 0) ? ($urandom_range(0, 2) != 0) : (wcnt >= stall);
      #1;
      acc  = coef_valid_i && coef_ready_o;
      hs   = out_valid_o && out_ready_i;
      last = 1'b0;
      hold = out_valid_o && !out_ready_i;
      if (hold) begin hd = out_dat_o; hsz = out_size_o; wcnt++; end
      if (hs) begin
        wcnt = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL extra_beat observed=%0h/%0d expected=none", out_dat_o, out_size_o);
        end else begin
          e = exp_q.pop_front();
          chk("beat_dat", 32'(out_dat_o), 32'(e[15:0]));
          chk("beat_size", 32'(out_size_o), 32'(e[20:16]));
          last = (exp_q.size() == 0);
        end
      end
      chk("block_done", 32'(block_done_o), 32'(last));
      if (acc) idx++;
      cyc++;
    end
    coef_valid_i = 1'b0;
    dc_clr_i     = 1'b0;
    if (cyc >= 4000) begin
      total++;
      bad++;
      $error("FAIL timeout observed=idx%0d/left%0d expected=done", idx, exp_q.size());
      exp_q.delete();
    end else if (abort_at < 0) begin
      chk("idle_ready", 32'(coef_ready_o), 32'd1);
      chk("idle_valid", 32'(out_valid_o), 32'd0);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 32'(coef_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_dat", 32'(out_dat_o), 32'd0);
    chk("rst_size", 32'(out_size_o), 32'd0);
    chk("rst_done", 32'(block_done_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; coef_valid_i = 1'b0; comp_i = 1'b0; dc_clr_i = 1'b0;
    tbl_we_i = 1'b0; out_ready_i = 1'b0; coef_i = 11'd0;
    tbl_addr_i = 10'd0; tbl_dat_i = 21'd0;
    mpred = '{0, 0};
    repeat (3) @(negedge clk_i);
    check_reset_outputs();
    rst_i = 1'b0;
    load_tables();

    // DC only, from cleared predictor
    clear_blk(); blk[0] = 11'd5;
    push_beat(3'b100, 3); push_beat(3'b101, 3); push_beat(4'b1010, 4);
    mpred = '{5, 0};
    run_block(0, 1'b1, 0, -1);

    // Same block, no clear: zero difference
    push_beat(2'b00, 2); push_beat(4'b1010, 4);
    run_block(0, 1'b0, 0, -1);

    // Negative DC and a single AC 1
    clear_blk(); blk[0] = 11'h7FD; blk[1] = 11'd1;
    push_beat(3'b011, 3); push_beat(2'b00, 2); push_beat(2'b00, 2);
    push_beat(1'b1, 1); push_beat(4'b1010, 4);
    mpred = '{-3, 0};
    run_block(0, 1'b1, 0, -1);

    // One ZRL ahead of a run-3 coefficient
    clear_blk(); blk[20] = 11'd2;
    push_beat(2'b00, 2); push_beat(11'h7F9, 11);
    push_beat(tcode[0][0][8'h32], tlen[0][0][8'h32]);
    push_beat(2'b10, 2); push_beat(4'b1010, 4);
    mpred = '{0, 0};
    run_block(0, 1'b1, 0, -1);

    // Last coefficient nonzero, saturation, multiple ZRLs, 5-cycle stalls
    clear_blk(); blk[0] = 11'h400; blk[5] = 11'd3; blk[40] = 11'h400; blk[63] = 11'h7F9;
    model_block(0, 1'b1);
    run_block(0, 1'b1, 5, -1);

    // Chroma table set and predictor, two consecutive blocks
    rand_blk(25); model_block(1, 1'b0); run_block(1, 1'b0, 0, -1);
    rand_blk(10); model_block(1, 1'b0); run_block(1, 1'b0, 1, -1);

    // Reset in the middle of a block
    rand_blk(40); model_block(0, 1'b0);
    run_block(0, 1'b0, 0, 30);
    out_ready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.delete();
    mpred = '{0, 0};
    load_tables();
    rand_blk(30); model_block(0, 1'b0); run_block(0, 1'b0, 0, -1);

    // Random blocks with random handshakes
    for (int b = 0; b < 14; b++) begin
      int cp;
      bit cl;
      cp = int'($urandom_range(0, 1));
      cl = ($urandom_range(0, 3) == 0);
      rand_blk(int'($urandom_range(3, 60)));
      model_block(cp, cl);
      run_block(cp, cl, (b % 2 == 0) ? -1 : int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
